uart_cmd_ctrl: RTL and testbench
================================

Name: uart_cmd_ctrl

Overview:
Command sequencer that sits between the uart block's byte handshakes and a simple 8-bit register bus. It parses a byte-oriented read/write protocol from the host, issues one bus transaction per command, and transmits a one-byte response. It replaces the loopback glue in top-level designs so the host can poke internal registers over serial. Handles one command at a time, with a bus timeout.

Parameters:
TIMEOUT, 255, number of cycles bus_req may stay high without bus_ack before aborting (1..65535)
CMD_WR, 8'h57, command byte for write ('W')
CMD_RD, 8'h52, command byte for read ('R')

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
uart_rx_byte  in  8  received byte from uart
uart_rx_valid  in  1  received byte available
uart_rx_ready  out  1  controller accepts received byte
uart_tx_byte  out  8  response byte to uart
uart_tx_valid  out  1  response byte valid
uart_tx_ready  in  1  uart can accept tx byte
bus_addr  out  8  register address
bus_wdata  out  8  write data
bus_we  out  1  1=write, 0=read; valid while bus_req
bus_req  out  1  transaction request, held until ack or timeout
bus_rdata  in  8  read data, valid in ack cycle
bus_ack  in  1  one-cycle transaction completion
busy  out  1  high in every state except S_CMD
timeout_count  out  8  saturating count of bus timeouts

Behaviour:
- Clock domain: clock. Reset: synchronous, active-high (reset); the block enters S_CMD on reset.
- Reset values: state=S_CMD, uart_tx_valid=0, uart_tx_byte=0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, timeout_count=0. uart_rx_ready=0 while reset is high.
- Handshakes: a byte transfers on a rising edge where valid&&ready are both high. uart_tx_byte is stable while uart_tx_valid is high. uart_tx_valid drops only after the handshake.
- uart_rx_ready = !reset && state in {S_CMD, S_ADDR, S_DATA} (combinational decode).
- States:
  - S_CMD: on accepted byte: CMD_WR or CMD_RD -> latch is_write, go to S_ADDR. Any other byte -> response 8'h3F ('?'), go to S_RESP.
  - S_ADDR: on accepted byte -> bus_addr <= byte. If write, go to S_DATA. If read, set bus_req=1 and bus_we=0, go to S_BUS.
  - S_DATA: on accepted byte -> bus_wdata <= byte, bus_req=1, bus_we=1, go to S_BUS.
  - S_BUS: bus_req is high from the first cycle in this state. On bus_ack: bus_req <= 0; response = bus_rdata (read) or 8'h4B ('K', write); go to S_RESP. Otherwise increment the wait counter. On the cycle the counter reaches TIMEOUT-1 with no ack: bus_req <= 0, response 8'hEE, timeout_count += 1 (saturates at 255), go to S_RESP.
  - S_RESP: uart_tx_valid=1 with the response byte. On tx handshake -> uart_tx_valid <= 0, go to S_CMD.
- Bus timing: bus_req rises one cycle after the last parameter byte is accepted. Ack in the first bus_req cycle is legal, giving a 1-cycle bus phase. Ack and timeout in the same cycle: ack wins, no timeout counted. bus_ack while bus_req is low is ignored.
- Response latency: uart_tx_valid rises the cycle after ack/timeout/bad command. After the tx handshake, uart_rx_ready is high again in the next cycle.
- The wait counter clears on entry to S_BUS. Its width is clog2(TIMEOUT+1).
- rx bytes arriving during S_BUS/S_RESP are not consumed (rx_ready low). The uart holds or drops them per its own overrun policy.
- Reset mid-operation: all outstanding bus_req/tx_valid deassert at the next edge. No partial response is sent. A parsed partial command is discarded.

Decomposition:
- Shared package uart_cmd_pkg holds:
  - the state enum S_CMD/S_ADDR/S_DATA/S_BUS/S_RESP
  - response constants RSP_ACK=8'h4B, RSP_ERR=8'h3F, RSP_TIMEOUT=8'hEE
  - default CMD_WR/CMD_RD values
- One natural sub-module: bus_timeout_timer (clear, enable, expired flag, parameterised TIMEOUT). The FSM stays in uart_cmd_ctrl.

Test Plan:
- Write: rx 57,10,A5 -> bus_req/bus_we=1, addr=10, wdata=A5 one cycle after third byte; ack after 3 cycles -> tx 4B; rx_ready high the cycle after tx handshake.
- Read: rx 52,22; slave acks in the first req cycle with rdata=3C -> bus_we=0, tx 3C; exactly one bus_req cycle.
- Bad command: rx 41 -> tx 3F, no bus_req. A following 52,01 with rdata=99 -> tx 99.
- Timeout: TIMEOUT=8, rx 52,05, no ack -> bus_req high exactly 8 cycles, tx EE, timeout_count=1. 300 timeouts -> timeout_count saturates at FF.
- Tx backpressure / collision: hold tx_ready low 20 cycles -> tx_valid and tx_byte stable, rx_ready low, no extra bus_req. With TIMEOUT=8, ack on the 8th cycle -> normal response, timeout_count unchanged.
- Reset mid-op: assert reset during S_BUS (bus_req=1) -> bus_req=0 and tx_valid=0 next edge, no tx. After release, 57,00,11 completes normally with tx 4B.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - shared states and protocol constants for the uart command sequencer
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    S_CMD,
    S_ADDR,
    S_DATA,
    S_BUS,
    S_RESP
  } state_e;

  localparam logic [7:0] RSP_ACK     = 8'h4B;
  localparam logic [7:0] RSP_ERR     = 8'h3F;
  localparam logic [7:0] RSP_TIMEOUT = 8'hEE;
  localparam logic [7:0] DEF_CMD_WR  = 8'h57;
  localparam logic [7:0] DEF_CMD_RD  = 8'h52;

endpackage

// File: rtl/bus_timeout_timer.sv
// rtl/bus_timeout_timer.sv - bus wait counter that flags the last allowed request cycle
module bus_timeout_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] count_q;

  always_ff @(posedge clock) begin
    if (reset || clear_i) begin
      count_q <= '0;
    end else if (enable_i) begin
      count_q <= count_q + W'(1);
    end
  end

  // Asserted during the TIMEOUT-th request cycle, so bus_req spans exactly TIMEOUT cycles.
  assign expired_o = enable_i && (count_q == LAST);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// rtl/uart_cmd_ctrl.sv - parses W/R commands from the uart, runs one register bus access, replies one byte
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int         TIMEOUT = 255,
  parameter logic [7:0] CMD_WR  = DEF_CMD_WR,
  parameter logic [7:0] CMD_RD  = DEF_CMD_RD
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] uart_rx_byte,
  input  logic       uart_rx_valid,
  output logic       uart_rx_ready,
  output logic [7:0] uart_tx_byte,
  output logic       uart_tx_valid,
  input  logic       uart_tx_ready,
  output logic [7:0] bus_addr,
  output logic [7:0] bus_wdata,
  output logic       bus_we,
  output logic       bus_req,
  input  logic [7:0] bus_rdata,
  input  logic       bus_ack,
  output logic       busy,
  output logic [7:0] timeout_count
);

  state_e     state_q;
  logic       is_write_q;
  logic [7:0] tx_byte_q;
  logic       tx_valid_q;
  logic [7:0] addr_q;
  logic [7:0] wdata_q;
  logic       we_q;
  logic       req_q;
  logic [7:0] timeout_count_q;
  logic       expired;
  logic       rx_fire;

  bus_timeout_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clock     (clock),
    .reset     (reset),
    .clear_i   (state_q != S_BUS),
    .enable_i  (state_q == S_BUS),
    .expired_o (expired)
  );

  assign uart_rx_ready = !reset && (state_q inside {S_CMD, S_ADDR, S_DATA});
  assign rx_fire       = uart_rx_valid && uart_rx_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= S_CMD;
      is_write_q      <= 1'b0;
      tx_byte_q       <= 8'h00;
      tx_valid_q      <= 1'b0;
      addr_q          <= 8'h00;
      wdata_q         <= 8'h00;
      we_q            <= 1'b0;
      req_q           <= 1'b0;
      timeout_count_q <= 8'h00;
    end else begin
      case (state_q)
        S_CMD: if (rx_fire) begin
          if (uart_rx_byte == CMD_WR || uart_rx_byte == CMD_RD) begin
            is_write_q <= (uart_rx_byte == CMD_WR);
            state_q    <= S_ADDR;
          end else begin
            tx_byte_q  <= RSP_ERR;
            tx_valid_q <= 1'b1;
            state_q    <= S_RESP;
          end
        end
        S_ADDR: if (rx_fire) begin
          addr_q <= uart_rx_byte;
          if (is_write_q) begin
            state_q <= S_DATA;
          end else begin
            req_q   <= 1'b1;
            we_q    <= 1'b0;
            state_q <= S_BUS;
          end
        end
        S_DATA: if (rx_fire) begin
          wdata_q <= uart_rx_byte;
          req_q   <= 1'b1;
          we_q    <= 1'b1;
          state_q <= S_BUS;
        end
        S_BUS: begin
          // Ack is checked first so an ack on the final allowed cycle is never counted as a timeout.
          if (bus_ack) begin
            req_q      <= 1'b0;
            tx_byte_q  <= we_q ? RSP_ACK : bus_rdata;
            tx_valid_q <= 1'b1;
            state_q    <= S_RESP;
          end else if (expired) begin
            req_q      <= 1'b0;
            tx_byte_q  <= RSP_TIMEOUT;
            tx_valid_q <= 1'b1;
            state_q    <= S_RESP;
            if (timeout_count_q != 8'hFF) begin
              timeout_count_q <= timeout_count_q + 8'd1;
            end
          end
        end
        S_RESP: if (uart_tx_ready) begin
          tx_valid_q <= 1'b0;
          state_q    <= S_CMD;
        end
        default: state_q <= S_CMD;
      endcase
    end
  end

  assign uart_tx_byte  = tx_byte_q;
  assign uart_tx_valid = tx_valid_q;
  assign bus_addr      = addr_q;
  assign bus_wdata     = wdata_q;
  assign bus_we        = we_q;
  assign bus_req       = req_q;
  assign busy          = (state_q != S_CMD);
  assign timeout_count = timeout_count_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb/tb_uart_cmd_ctrl.sv - scoreboard bench for uart_cmd_ctrl with TIMEOUT=8
module tb_uart_cmd_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] uart_rx_byte;
  logic       uart_rx_valid;
  logic       uart_rx_ready;
  logic [7:0] uart_tx_byte;
  logic       uart_tx_valid;
  logic       uart_tx_ready;
  logic [7:0] bus_addr;
  logic [7:0] bus_wdata;
  logic       bus_we;
  logic       bus_req;
  logic [7:0] bus_rdata;
  logic       bus_ack;
  logic       busy;
  logic [7:0] timeout_count;

  int checks   = 0;
  int failures = 0;
  int req_cycles = 0;
  int tx_count   = 0;
  logic [7:0] exp_q[$];

  uart_cmd_ctrl #(.TIMEOUT(8)) dut (
    .clock         (clock),
    .reset         (reset),
    .uart_rx_byte  (uart_rx_byte),
    .uart_rx_valid (uart_rx_valid),
    .uart_rx_ready (uart_rx_ready),
    .uart_tx_byte  (uart_tx_byte),
    .uart_tx_valid (uart_tx_valid),
    .uart_tx_ready (uart_tx_ready),
    .bus_addr      (bus_addr),
    .bus_wdata     (bus_wdata),
    .bus_we        (bus_we),
    .bus_req       (bus_req),
    .bus_rdata     (bus_rdata),
    .bus_ack       (bus_ack),
    .busy          (busy),
    .timeout_count (timeout_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: samples on the falling edge; a tx handshake happens at the following rising edge.
  logic       prev_hold = 1'b0;
  logic [7:0] prev_byte = 8'h00;
  always @(negedge clock) begin
    if (!reset) begin
      if (bus_req) req_cycles++;
      if (prev_hold && uart_tx_valid) check("tx_byte_stable", uart_tx_byte, prev_byte);
      if (uart_tx_valid && uart_tx_ready) begin
        tx_count++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_tx: got %h expected no response", uart_tx_byte);
        end else begin
          check("tx_byte", uart_tx_byte, exp_q.pop_front());
        end
      end
      prev_hold = uart_tx_valid && !uart_tx_ready;
      prev_byte = uart_tx_byte;
    end else begin
      prev_hold = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    uart_rx_byte  = b;
    uart_rx_valid = 1'b1;
    while (!uart_rx_ready && n < 100) begin
      tick();
      n++;
    end
    if (n == 100) check("rx_accept_timeout", 32'(n), 32'd0);
    tick();
    uart_rx_valid = 1'b0;
  endtask

  task automatic wait_tx();
    int n = 0;
    while ((exp_q.size() != 0 || uart_tx_valid) && n < 200) begin
      tick();
      n++;
    end
    if (n == 200) check("tx_wait_timeout", 32'(n), 32'd0);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!uart_tx_valid && n < 50) begin
      tick();
      n++;
    end
    if (n == 50) check("tx_valid_timeout", 32'(n), 32'd0);
  endtask

  int base_req;
  int base_tx;

  initial begin
    reset = 1'b1;
    uart_rx_byte = 8'h00;
    uart_rx_valid = 1'b0;
    uart_tx_ready = 1'b1;
    bus_rdata = 8'h00;
    bus_ack = 1'b0;
    repeat (3) tick();
    check("rst_rx_ready", uart_rx_ready, 0);
    check("rst_tx_valid", uart_tx_valid, 0);
    check("rst_tx_byte", uart_tx_byte, 8'h00);
    check("rst_bus", {bus_req, bus_we, bus_addr, bus_wdata}, 0);
    check("rst_timeout_count", timeout_count, 8'h00);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    tick();
    check("idle_rx_ready", uart_rx_ready, 1);

    // Stray ack while idle must be ignored.
    bus_ack = 1'b1; tick(); bus_ack = 1'b0; tick();
    check("stray_ack", {uart_tx_valid, busy}, 0);

    // Write with ack on third request cycle
    base_req = req_cycles;
    exp_q.push_back(8'h4B);
    send_byte(8'h57); send_byte(8'h10); send_byte(8'hA5);
    check("wr_bus", {bus_req, bus_we, bus_addr, bus_wdata}, {1'b1, 1'b1, 8'h10, 8'hA5});
    check("wr_rx_ready_low", uart_rx_ready, 0);
    tick(); tick();
    bus_ack = 1'b1; tick(); bus_ack = 1'b0;
    check("wr_resp", {uart_tx_valid, bus_req}, {1'b1, 1'b0});
    tick();
    check("wr_after_hs", {uart_rx_ready, uart_tx_valid}, {1'b1, 1'b0});
    check("wr_req_cycles", req_cycles - base_req, 3);

    // Read acked in first request cycle
    base_req = req_cycles;
    exp_q.push_back(8'h3C);
    send_byte(8'h52); send_byte(8'h22);
    check("rd_bus", {bus_req, bus_we, bus_addr}, {1'b1, 1'b0, 8'h22});
    bus_rdata = 8'h3C; bus_ack = 1'b1; tick(); bus_ack = 1'b0;
    wait_tx();
    check("rd_req_cycles", req_cycles - base_req, 1);

    // Bad command then read
    base_req = req_cycles;
    exp_q.push_back(8'h3F);
    send_byte(8'h41);
    check("bad_resp", {uart_tx_valid, bus_req, uart_rx_ready}, {1'b1, 1'b0, 1'b0});
    wait_tx();
    check("bad_no_req", req_cycles - base_req, 0);
    exp_q.push_back(8'h99);
    send_byte(8'h52); send_byte(8'h01);
    bus_rdata = 8'h99; bus_ack = 1'b1; tick(); bus_ack = 1'b0;
    wait_tx();
    check("bad_then_rd_req", req_cycles - base_req, 1);

    // Timeout
    base_req = req_cycles;
    exp_q.push_back(8'hEE);
    send_byte(8'h52); send_byte(8'h05);
    wait_valid();
    check("to_req_cycles", req_cycles - base_req, 8);
    check("to_count1", timeout_count, 8'h01);
    wait_tx();

    // Ack on the final allowed cycle beats the timeout
    base_req = req_cycles;
    exp_q.push_back(8'h5A);
    send_byte(8'h52); send_byte(8'h07);
    repeat (7) tick();
    bus_rdata = 8'h5A; bus_ack = 1'b1; tick(); bus_ack = 1'b0;
    check("coll_valid", uart_tx_valid, 1);
    check("coll_req_cycles", req_cycles - base_req, 8);
    check("coll_count", timeout_count, 8'h01);
    wait_tx();

    // Tx backpressure for 20 cycles with a pending rx byte
    base_req = req_cycles;
    uart_tx_ready = 1'b0;
    exp_q.push_back(8'h4B);
    send_byte(8'h57); send_byte(8'h30); send_byte(8'h44);
    bus_ack = 1'b1; tick(); bus_ack = 1'b0;
    uart_rx_byte = 8'h52; uart_rx_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      check("bp_hold", {uart_tx_valid, uart_tx_byte, uart_rx_ready, bus_req}, {1'b1, 8'h4B, 1'b0, 1'b0});
      tick();
    end
    uart_rx_valid = 1'b0;
    uart_tx_ready = 1'b1;
    wait_tx();
    check("bp_req_cycles", req_cycles - base_req, 1);

    // Timeout counter saturation (1 already counted)
    for (int i = 0; i < 299; i++) begin
      exp_q.push_back(8'hEE);
      send_byte(8'h52); send_byte(8'h05);
      wait_tx();
      if (i == 252) check("sat_count_fe", timeout_count, 8'hFE);
      if (i == 253) check("sat_count_ff", timeout_count, 8'hFF);
    end
    check("sat_count_final", timeout_count, 8'hFF);

    // Reset during bus phase
    base_tx = tx_count;
    send_byte(8'h52); send_byte(8'h09);
    check("mid_req", bus_req, 1);
    reset = 1'b1; tick();
    check("mid_rst", {bus_req, uart_tx_valid, uart_rx_ready}, 0);
    check("mid_rst_count", timeout_count, 8'h00);
    reset = 1'b0;
    repeat (3) tick();
    check("mid_no_tx", tx_count - base_tx, 0);
    exp_q.push_back(8'h4B);
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h11);
    check("post_rst_bus", {bus_req, bus_we, bus_addr, bus_wdata}, {1'b1, 1'b1, 8'h00, 8'h11});
    bus_ack = 1'b1; tick(); bus_ack = 1'b0;
    wait_tx();
    repeat (3) tick();
    check("scoreboard_empty", exp_q.size(), 0);
    check("tx_total_after_rst", tx_count - base_tx, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
